// File: rtl/mult_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter: sizes, FSM state and the timeout counter.
package mult_arbiter_pkg;

  localparam int unsigned DATA_LENGTH    = 64;
  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned TIMEOUT_CYCLES = 1000;
  localparam int unsigned CounterWidth   = 16;

  typedef logic [CounterWidth-1:0] counter_t;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StCompute,
    StFinish
  } state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, response and multiplier-core signals of the arbiter, bundled with
// arbiter-side (slave) and environment-side (master) views.
interface mult_arbiter_if #(
  parameter int unsigned NUM_REQ     = mult_arbiter_pkg::NUM_REQ,
  parameter int unsigned DATA_LENGTH = mult_arbiter_pkg::DATA_LENGTH
);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_LENGTH-1:0] req_b;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [NUM_REQ-1:0]                  rsp_ready;
  logic [2*DATA_LENGTH-1:0]            rsp_result;
  logic                                rsp_err;
  logic                                mul_start;
  logic [DATA_LENGTH-1:0]              mul_a;
  logic [DATA_LENGTH-1:0]              mul_b;
  logic                                mul_done;
  logic [2*DATA_LENGTH-1:0]            mul_result;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
    output req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_a, mul_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_done, mul_result,
    input  req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin grant: picks the first requester after last_grant_i, cyclically.
module mult_arbiter_rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IdxW-1:0]    grant_idx_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    idx         = '0;
    found       = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IdxW'((32'(last_grant_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier core among NUM_REQ requesters with round-robin
// arbitration, a start/done handshake to the core and a completion timeout.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = mult_arbiter_pkg::NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = mult_arbiter_pkg::TIMEOUT_CYCLES
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus_io
);

  localparam int unsigned     IdxW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IdxW-1:0] LastInit    = IdxW'(NUM_REQ - 1);
  localparam counter_t        TimeoutLast = counter_t'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic [IdxW-1:0]          last_q, last_d;
  logic [IdxW-1:0]          gnt_q, gnt_d;
  logic [DATA_LENGTH-1:0]   mul_a_q, mul_a_d;
  logic [DATA_LENGTH-1:0]   mul_b_q, mul_b_d;
  counter_t                 cnt_q, cnt_d;
  logic [2*DATA_LENGTH-1:0] result_q, result_d;
  logic                     err_q, err_d;

  logic [NUM_REQ-1:0]       rr_grant;
  logic [IdxW-1:0]          rr_idx;

  mult_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_grant (
    .req_i        (bus_io.req_valid),
    .last_grant_i (last_q),
    .grant_o      (rr_grant),
    .grant_idx_o  (rr_idx)
  );

  // Handshake outputs are gated by rst so nothing leaks during the reset cycle itself.
  assign bus_io.req_ready  = (state_q == StIdle && !rst) ? rr_grant : '0;
  assign bus_io.rsp_valid  = (state_q == StFinish && !rst) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign bus_io.mul_start  = (state_q == StInit) && !rst;
  assign bus_io.mul_a      = mul_a_q;
  assign bus_io.mul_b      = mul_b_q;
  assign bus_io.rsp_result = result_q;
  assign bus_io.rsp_err    = err_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (|bus_io.req_valid) begin
          gnt_d   = rr_idx;
          mul_a_d = bus_io.req_a[rr_idx];
          mul_b_d = bus_io.req_b[rr_idx];
          state_d = StInit;
        end
      end
      StInit: begin
        cnt_d   = '0;
        state_d = StCompute;
      end
      StCompute: begin
        cnt_d = cnt_q + 1'b1;
        // A completion on the last allowed cycle wins over the timeout.
        if (bus_io.mul_done) begin
          result_d = bus_io.mul_result;
          err_d    = 1'b0;
          state_d  = StFinish;
        end else if (cnt_q == TimeoutLast) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StFinish;
        end
      end
      StFinish: begin
        if (bus_io.rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= LastInit;
      gnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier core, round-robin grant model and a
// response scoreboard, driven by one task per scenario.
module tb_mult_arbiter;
  import mult_arbiter_pkg::*;

  localparam int unsigned TO = 32;
  localparam int unsigned DL = DATA_LENGTH;

  typedef struct {
    logic              idx;
    logic [2*DL-1:0]   result;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mult_arbiter_if bus ();

  mult_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nacc = 0;
  int   last_m = 1;
  int   core_lat = 4;
  int   core_cnt = 0;
  bit   stray_req = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_grant(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0);
    return v[1];
  endfunction

  // Core model: mul_done core_lat cycles after the cycle carrying mul_start; 0 = never.
  always @(posedge clk) begin
    #1;
    bus.mul_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.mul_done   = 1'b1;
        bus.mul_result = (2*DL)'(bus.mul_a) * (2*DL)'(bus.mul_b);
      end
    end
    if (stray_req) begin
      bus.mul_done   = 1'b1;
      bus.mul_result = '1;
      stray_req      = 1'b0;
    end
    if (bus.mul_start && core_lat > 0) core_cnt = core_lat;
  end

  // Scoreboard: push on request transfer, pop and compare on response acceptance.
  always @(negedge clk) begin : mon
    logic g;
    exp_t e;
    if (!rst) begin
      if ((bus.req_valid & bus.req_ready) != 2'b00) begin
        g = model_grant(bus.req_valid, last_m);
        checks++;
        if (bus.req_ready !== (2'b01 << g)) begin
          errors++;
          $display("FAIL grant: req_ready=%b required %b", bus.req_ready, 2'b01 << g);
        end
        e.idx    = g;
        e.err    = (core_lat == 0 || core_lat > TO);
        e.result = e.err ? '0 : (2*DL)'(bus.req_a[g]) * (2*DL)'(bus.req_b[g]);
        sb.push_back(e);
      end
      if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rsp_valid=%b with no outstanding request", bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_valid !== (2'b01 << e.idx) || bus.rsp_result !== e.result ||
              bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL sb_rsp: valid=%b result=%h err=%b required valid=%b result=%h err=%b",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_err, 2'b01 << e.idx, e.result, e.err);
          end
          last_m = e.idx;
        end
        nacc++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    last_m = 1;
  endtask

  task automatic wait_xfer(input int i, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid);
    end
    checks++;
    if (bus.mul_start !== 1'b0) begin
      errors++; $display("FAIL reset_mul_start: got %b want 0", bus.mul_start);
    end
    checks++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_result !== '0) begin
      errors++; $display("FAIL reset_rsp: err=%b result=%h want 0/0", bus.rsp_err, bus.rsp_result);
    end
    checks++;
    if (bus.mul_a !== '0 || bus.mul_b !== '0) begin
      errors++; $display("FAIL reset_operands: a=%h b=%h want 0/0", bus.mul_a, bus.mul_b);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b0;
    sb.delete();
    last_m = 1;
  endtask

  task automatic test_single();
    bit ok;
    int t0;
    int t1;
    core_lat = 4;
    @(posedge clk); #1;
    bus.req_a[0] = DL'(3);
    bus.req_b[0] = DL'(5);
    bus.req_valid = 2'b01;
    wait_xfer(0, ok, t0);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_xfer: got no transfer, want one"); end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.mul_start !== 1'b1 || bus.mul_a !== DL'(3) || bus.mul_b !== DL'(5)) begin
      errors++;
      $display("FAIL single_start: start=%b a=%0d b=%0d want 1/3/5",
               bus.mul_start, bus.mul_a, bus.mul_b);
    end
    @(negedge clk);
    checks++;
    if (bus.mul_start !== 1'b0) begin
      errors++; $display("FAIL single_start_pulse: got %b want 0", bus.mul_start);
    end
    wait_rsp(20, ok, t1);
    checks++;
    if (!ok || t1 - t0 != 6) begin
      errors++; $display("FAIL single_latency: got %0d (seen=%b) want 6", t1 - t0, ok);
    end
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== (2*DL)'(15) || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b result=%0d err=%b want 01/15/0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    bit   ok;
    logic g;
    int   n0;
    do_reset();
    core_lat = 2;
    n0 = nacc;
    bus.req_a[0] = DL'(7);
    bus.req_b[0] = DL'(9);
    bus.req_a[1] = DL'(11);
    bus.req_b[1] = DL'(13);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      g  = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clk);
        if ((bus.req_valid & bus.req_ready) != 2'b00) begin
          ok = 1'b1;
          g  = bus.req_ready[1];
        end
      end
      checks++;
      if (!ok || g !== k[0]) begin
        errors++; $display("FAIL contention_order[%0d]: got %b (seen=%b) want %b", k, g, ok, k[0]);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    for (int w = 0; w < 50 && nacc < n0 + 4; w++) @(negedge clk);
    checks++;
    if (nacc != n0 + 4) begin
      errors++; $display("FAIL contention_rsps: got %0d want 4", nacc - n0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    bit ok;
    int t0;
    int t1;
    core_lat = 3;
    bus.req_a[1] = '1;
    bus.req_b[1] = '1;
    bus.req_valid = 2'b10;
    wait_xfer(1, ok, t0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(20, ok, t1);
    checks++;
    if (!ok || bus.rsp_valid !== 2'b10 ||
        bus.rsp_result !== 128'hFFFFFFFFFFFFFFFE0000000000000001) begin
      errors++;
      $display("FAIL max_operands: valid=%b result=%h want 10/fffffffffffffffe0000000000000001",
               bus.rsp_valid, bus.rsp_result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int   lats[3] = '{0, TO, TO + 1};
    logic errs[3] = '{1'b1, 1'b0, 1'b1};
    bit   ok;
    int   t0;
    int   t1;
    for (int k = 0; k < 3; k++) begin
      core_lat = lats[k];
      bus.req_a[0] = DL'(6);
      bus.req_b[0] = DL'(7);
      bus.req_valid = 2'b01;
      wait_xfer(0, ok, t0);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      wait_rsp(TO + 20, ok, t1);
      checks++;
      if (!ok || t1 - t0 != int'(TO) + 2) begin
        errors++;
        $display("FAIL timeout_latency[%0d]: got %0d (seen=%b) want %0d", k, t1 - t0, ok, TO + 2);
      end
      checks++;
      if (bus.rsp_err !== errs[k] ||
          bus.rsp_result !== (errs[k] ? (2*DL)'(0) : (2*DL)'(42))) begin
        errors++;
        $display("FAIL timeout_rsp[%0d]: err=%b result=%0d want err=%b", k, bus.rsp_err,
                 bus.rsp_result, errs[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int t0;
    int t1;
    int n0;
    core_lat = 3;
    bus.rsp_ready = 2'b10;
    bus.req_a[0] = DL'(100);
    bus.req_b[0] = DL'(200);
    bus.req_a[1] = DL'(4);
    bus.req_b[1] = DL'(5);
    bus.req_valid = 2'b01;
    wait_xfer(0, ok, t0);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    wait_rsp(20, ok, t1);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== (2*DL)'(20000) ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b result=%0d err=%b ready=%b want 01/20000/0/00",
                 k, bus.rsp_valid, bus.rsp_result, bus.rsp_err, bus.req_ready);
      end
      @(negedge clk);
    end
    n0 = nacc;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    wait_xfer(1, ok, t0);
    checks++;
    if (!ok || nacc != n0 + 1) begin
      errors++; $display("FAIL backpressure_release: xfer=%b accepted=%0d want 1/1", ok, nacc - n0);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_rsp(20, ok, t1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int t0;
    core_lat = 10;
    bus.req_a[0] = DL'(9);
    bus.req_b[0] = DL'(9);
    bus.req_valid = 2'b01;
    wait_xfer(0, ok, t0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    last_m = 1;
    stray_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.mul_start !== 1'b0 || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL reset_abort[%0d]: valid=%b start=%b ready=%b want 00/0/00",
                 k, bus.rsp_valid, bus.mul_start, bus.req_ready);
      end
    end
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 2'b11;
    bus.mul_done   = 1'b0;
    bus.mul_result = '0;
    test_reset();
    test_single();
    test_contention();
    test_max();
    test_timeout();
    test_backpressure();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d outstanding want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one multiplier core.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, max cycles waited for mul_done (must fit counter_t).
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester operand-valid.
REQ-006 SHALL have port req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a  in  NUM_REQ x DATA_LENGTH  operand A per requester.
REQ-008 SHALL have port req_b  in  NUM_REQ x DATA_LENGTH  operand B per requester.
REQ-009 SHALL have port rsp_valid  out  NUM_REQ  result-valid, one-hot or zero.
REQ-010 SHALL have port rsp_ready  in  NUM_REQ  per-requester result accept.
REQ-011 SHALL have port rsp_result  out  2*DATA_LENGTH  product, shared by all requesters.
REQ-012 SHALL have port rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-013 SHALL have port mul_start  out  1  one-cycle start pulse to core.
REQ-014 SHALL have ports mul_a, mul_b  out  DATA_LENGTH each  registered operands to core.
REQ-015 SHALL have port mul_done  in  1  core completion pulse.
REQ-016 SHALL have port mul_result  in  2*DATA_LENGTH  core product, valid with mul_done.

Function
REQ-017 SHALL sequence with FSM states idle, init, compute, finish.
REQ-018 idle: SHALL grant when any req_valid set; grant = only valid requester, or if both valid, requester other than last_grant.
REQ-019 idle: SHALL assert req_ready[g] combinationally in the grant cycle only; transfer = req_valid[g] & req_ready[g]; mul_a/mul_b latched from req_a[g]/req_b[g]; next state init.
REQ-020 init: SHALL assert mul_start exactly one cycle, clear timeout counter, go to compute.
REQ-021 compute: SHALL increment counter each cycle; on mul_done capture mul_result into rsp_result, rsp_err<=0, go to finish.
REQ-022 compute: if counter reaches TIMEOUT_CYCLES-1 with no mul_done, SHALL set rsp_result<=0, rsp_err<=1, go to finish; mul_done in same cycle takes priority (no error).
REQ-023 finish: SHALL hold rsp_valid[g]=1, rsp_result, rsp_err stable until rsp_ready[g]; then last_grant<=g, next state idle.
REQ-024 SHALL ignore mul_done outside compute and rsp_ready of non-granted requesters.
REQ-025 SHALL never assert req_ready outside idle; requester valid changes in other states have no effect.
REQ-026 Latency: transfer at cycle T -> mul_start at T+1; mul_done at T+1+N -> rsp_valid at T+2+N; minimum accept-to-accept interval 4 cycles.
REQ-027 mul_a/mul_b SHALL stay stable from init until return to idle.

Reset
REQ-028 On rst, SHALL enter idle; req_ready=0, rsp_valid=0, mul_start=0, rsp_err=0, rsp_result=0, mul_a=mul_b=0, counter=0.
REQ-029 last_grant SHALL reset to NUM_REQ-1 so requester 0 wins first contention.
REQ-030 rst mid-operation SHALL abort immediately; a later mul_done from the aborted job SHALL be ignored.

Structure
REQ-031 Shared package SHALL hold DATA_LENGTH, NUM_REQ, TIMEOUT_CYCLES, state_t (idle, init, compute, finish) and counter_t; module reuses state_t.
REQ-032 Grant selection SHALL be a sub-module rr_grant (req vector, last_grant -> one-hot grant); multiplier core is external.

Verification
REQ-033 Single request: req_valid=01, a=3, b=5, core done after 4 cycles -> rsp_valid=01, rsp_result=15, rsp_err=0, rsp_valid 6 cycles after transfer.
REQ-034 Contention after reset: req_valid=11 held -> grants alternate 0,1,0,1; each rsp_valid goes only to granted requester.
REQ-035 Max operands: a=b=2^64-1 -> rsp_result=0xFFFFFFFFFFFFFFFE0000000000000001.
REQ-036 Timeout: core never asserts mul_done -> rsp_valid after TIMEOUT_CYCLES in compute, rsp_err=1, rsp_result=0; mul_done on final cycle -> rsp_err=0.
REQ-037 Backpressure: rsp_ready low 10 cycles in finish -> rsp_valid/result stable, no new req_ready until accepted.
REQ-038 Reset in compute, then stray mul_done -> FSM stays idle, no rsp_valid, mul_start=0.
